config_stream_loader: RTL and testbench

Writer side of the block-style configuration interface. Accepts a serial configuration bitstream over a valid/ready handshake and assembles it into MEM_SIZE-bit words. Drives each word onto a shared `config_out` bus with a one-cycle, one-hot `cen` strobe per target latch block. One instance sits at the top of a CLB tile and loads NUM_BLOCKS `config_in`/`cen` latch blocks in order.

---
 rtl/config_stream_loader_if.sv | 19 +
 rtl/config_stream_loader.sv | 121 ++++++++++++
 tb/tb_config_stream_loader.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/config_stream_loader_if.sv
// Serial configuration bit stream handshake (valid/ready).
// The master drives bits; the loader (slave) signals when it will accept one.
interface config_stream_loader_if;
    logic bit_in;
    logic bit_valid;
    logic bit_ready;

    modport master (
        output bit_in,
        output bit_valid,
        input  bit_ready
    );

    modport slave (
        input  bit_in,
        input  bit_valid,
        output bit_ready
    );
endinterface

// File: rtl/config_stream_loader.sv
// Assembles an LSB-first serial bitstream into MEM_SIZE-bit words and writes
// them in order to NUM_BLOCKS latch blocks through a shared bus and a one-hot cen strobe.
module config_stream_loader #(
    parameter int unsigned MEM_SIZE   = 16,
    parameter int unsigned NUM_BLOCKS = 8
) (
    input  logic                    cclk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    abort,
    config_stream_loader_if.slave   s_bit,
    output logic [MEM_SIZE-1:0]     config_out,
    output logic [NUM_BLOCKS-1:0]   cen,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned CNT_W = $clog2(MEM_SIZE + 1);
    localparam int unsigned BLK_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WRITE,
        DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BLK_W-1:0]        blk_q, blk_d;
    logic [MEM_SIZE-1:0]     config_out_q, config_out_d;
    logic [NUM_BLOCKS-1:0]   cen_q, cen_d;
    logic                    bit_ready_q, bit_ready_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        blk_d        = blk_q;
        config_out_d = config_out_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = SHIFT;
                    cnt_d        = '0;
                    blk_d        = '0;
                    config_out_d = '0;
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (s_bit.bit_valid && bit_ready_q) begin
                    config_out_d = {s_bit.bit_in, config_out_q[MEM_SIZE-1:1]};
                    if (cnt_q == CNT_W'(MEM_SIZE - 1)) begin
                        state_d = WRITE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            WRITE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (blk_q == BLK_W'(NUM_BLOCKS - 1)) begin
                    state_d = DONE;
                end else begin
                    blk_d   = blk_q + BLK_W'(1);
                    state_d = SHIFT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so the flops line up with the state they describe.
        bit_ready_d = (state_d == SHIFT);
        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        cen_d       = '0;
        for (int unsigned k = 0; k < NUM_BLOCKS; k++) begin
            cen_d[k] = (state_d == WRITE) && (blk_d == BLK_W'(k));
        end
    end

    always_ff @(posedge cclk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            blk_q        <= '0;
            config_out_q <= '0;
            cen_q        <= '0;
            bit_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            blk_q        <= blk_d;
            config_out_q <= config_out_d;
            cen_q        <= cen_d;
            bit_ready_q  <= bit_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign s_bit.bit_ready = bit_ready_q;
    assign config_out      = config_out_q;
    assign cen             = cen_q;
    assign busy            = busy_q;
    assign done            = done_q;

endmodule

// File: tb/tb_config_stream_loader.sv
// Directed bench for config_stream_loader: default 16x8 instance plus a 4x1 instance.
module tb_config_stream_loader;

    logic        cclk = 1'b0;
    logic        rst  = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] config_out;
    logic [7:0]  cen;
    logic        busy;
    logic        done;

    logic        start4 = 1'b0;
    logic        abort4 = 1'b0;
    logic [3:0]  config_out4;
    logic [0:0]  cen4;
    logic        busy4;
    logic        done4;

    config_stream_loader_if s_if ();
    config_stream_loader_if s4_if ();

    config_stream_loader #(.MEM_SIZE(16), .NUM_BLOCKS(8)) u_dut (
        .cclk       (cclk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .s_bit      (s_if),
        .config_out (config_out),
        .cen        (cen),
        .busy       (busy),
        .done       (done)
    );

    config_stream_loader #(.MEM_SIZE(4), .NUM_BLOCKS(1)) u_dut4 (
        .cclk       (cclk),
        .rst        (rst),
        .start      (start4),
        .abort      (abort4),
        .s_bit      (s4_if),
        .config_out (config_out4),
        .cen        (cen4),
        .busy       (busy4),
        .done       (done4)
    );

    always #5 cclk = ~cclk;

    int n_checks = 0;
    int n_pass   = 0;

    // Strobe and done activity observed on the default instance.
    int         cen_cnt    = 0;
    int         cen_consec = 0;
    int         done_cnt   = 0;
    logic [7:0] cen_prev   = '0;

    always @(negedge cclk) begin
        if (cen != 8'h00) cen_cnt++;
        if (cen != 8'h00 && cen_prev != 8'h00) cen_consec++;
        cen_prev = cen;
        if (done) done_cnt++;
    end

    logic [15:0] words [8] = '{16'h0001, 16'h8000, 16'hA5A5, 16'h5A5A,
                               16'hFFFF, 16'h0000, 16'h1234, 16'hCAFE};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge cclk);
        #1;
    endtask

    // Feed bits first..last of w; a set stall bit inserts one idle cycle before that bit.
    task automatic shift_bits(input logic [15:0] w, input int unsigned first,
                              input int unsigned last, input logic [15:0] stall);
        for (int unsigned i = first; i <= last; i++) begin
            if (stall[i]) begin
                s_if.bit_valid = 1'b0;
                s_if.bit_in    = ~w[i];
                tick();
                check("stall_cen", 32'(cen), 32'h0);
                check("stall_ready", 32'(s_if.bit_ready), 32'h1);
            end
            s_if.bit_valid = 1'b1;
            s_if.bit_in    = w[i];
            tick();
        end
    endtask

    task automatic run_session(input logic use_stall);
        int cen_base;
        int done_base;
        logic [15:0] mask;
        cen_base  = cen_cnt;
        done_base = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("sess_busy", 32'(busy), 32'h1);
        check("sess_ready", 32'(s_if.bit_ready), 32'h1);
        check("sess_cfg_clr", 32'(config_out), 32'h0);
        for (int unsigned b = 0; b < 8; b++) begin
            mask = use_stall ? 16'($urandom) : 16'h0000;
            shift_bits(words[b], 0, 15, mask);
            check("wr_cen", 32'(cen), 32'(8'h01 << b));
            check("wr_cfg", 32'(config_out), 32'(words[b]));
            check("wr_ready", 32'(s_if.bit_ready), 32'h0);
            s_if.bit_valid = 1'b1;
            s_if.bit_in    = 1'b1;
            tick();
            if (b < 7) begin
                check("post_wr_cfg", 32'(config_out), 32'(words[b]));
                check("post_wr_cen", 32'(cen), 32'h0);
            end else begin
                check("done_pulse", 32'(done), 32'h1);
                check("done_cen", 32'(cen), 32'h0);
                check("done_cfg", 32'(config_out), 32'(words[7]));
            end
        end
        s_if.bit_valid = 1'b0;
        tick();
        check("idle_done", 32'(done), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_cfg_hold", 32'(config_out), 32'(words[7]));
        check("sess_cen_count", 32'(cen_cnt - cen_base), 32'd8);
        check("sess_done_count", 32'(done_cnt - done_base), 32'd1);
    endtask

    initial begin
        logic [3:0] w4;
        int cen_base;
        int done_base;
        w4 = 4'b1101;
        s_if.bit_in = 1'b0;
        s_if.bit_valid = 1'b1;
        s4_if.bit_in = 1'b0;
        s4_if.bit_valid = 1'b1;

        // Reset with bits offered and no start.
        rst = 1'b1;
        tick();
        tick();
        check("rst_cfg", 32'(config_out), 32'h0);
        check("rst_cen", 32'(cen), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_ready", 32'(s_if.bit_ready), 32'h0);
        rst = 1'b0;
        s_if.bit_in = 1'b1;
        s4_if.bit_in = 1'b1;
        repeat (3) tick();
        check("idle_no_accept", 32'(config_out), 32'h0);
        check("idle_no_accept4", 32'(config_out4), 32'h0);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_ready", 32'(s_if.bit_ready), 32'h0);
        s_if.bit_valid = 1'b0;

        // Single block, 4-bit word 1,0,1,1 LSB-first -> 4'b1101.
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("s4_busy", 32'(busy4), 32'h1);
        check("s4_ready", 32'(s4_if.bit_ready), 32'h1);
        for (int unsigned i = 0; i < 4; i++) begin
            s4_if.bit_valid = 1'b1;
            s4_if.bit_in    = w4[i];
            tick();
        end
        s4_if.bit_valid = 1'b0;
        check("s4_wr_cen", 32'(cen4), 32'h1);
        check("s4_wr_cfg", 32'(config_out4), 32'hD);
        check("s4_wr_ready", 32'(s4_if.bit_ready), 32'h0);
        tick();
        check("s4_done", 32'(done4), 32'h1);
        check("s4_done_cen", 32'(cen4), 32'h0);
        tick();
        check("s4_idle_busy", 32'(busy4), 32'h0);
        check("s4_idle_done", 32'(done4), 32'h0);
        check("s4_cfg_hold", 32'(config_out4), 32'hD);

        // Full session, continuous then with backpressure.
        run_session(1'b0);
        run_session(1'b1);
        check("cen_never_back_to_back", 32'(cen_consec), 32'h0);

        // Abort in the SHIFT cycle after block 2's WRITE.
        cen_base  = cen_cnt;
        done_base = done_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int unsigned b = 0; b < 3; b++) begin
            shift_bits(words[b], 0, 15, 16'h0000);
            check("ab_wr_cen", 32'(cen), 32'(8'h01 << b));
            check("ab_wr_cfg", 32'(config_out), 32'(words[b]));
            s_if.bit_valid = 1'b0;
            tick();
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab_busy", 32'(busy), 32'h0);
        check("ab_ready", 32'(s_if.bit_ready), 32'h0);
        check("ab_done", 32'(done), 32'h0);
        check("ab_cen", 32'(cen), 32'h0);
        tick();
        check("ab_cen_count", 32'(cen_cnt - cen_base), 32'd3);
        check("ab_done_count", 32'(done_cnt - done_base), 32'd0);

        // Restart from block 0, then abort coinciding with WRITE.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rs_cfg_clr", 32'(config_out), 32'h0);
        check("rs_busy", 32'(busy), 32'h1);
        shift_bits(16'h0F0F, 0, 15, 16'h0000);
        check("rs_wr_cen", 32'(cen), 32'h01);
        check("rs_wr_cfg", 32'(config_out), 32'h0F0F);
        s_if.bit_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abw_busy", 32'(busy), 32'h0);
        check("abw_cen", 32'(cen), 32'h0);
        check("abw_done", 32'(done), 32'h0);

        // Reset mid-SHIFT.
        start = 1'b1;
        tick();
        start = 1'b0;
        shift_bits(16'hFFFF, 0, 4, 16'h0000);
        s_if.bit_valid = 1'b0;
        check("mr_partial", 32'(config_out), 32'hF800);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_cfg", 32'(config_out), 32'h0);
        check("mr_busy", 32'(busy), 32'h0);
        check("mr_ready", 32'(s_if.bit_ready), 32'h0);
        check("mr_cen", 32'(cen), 32'h0);
        check("mr_done", 32'(done), 32'h0);

        // start pulsed during SHIFT must not disturb the partial word.
        start = 1'b1;
        tick();
        start = 1'b0;
        shift_bits(16'h3C96, 0, 7, 16'h0000);
        s_if.bit_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("is_cfg", 32'(config_out), 32'h9600);
        check("is_busy", 32'(busy), 32'h1);
        check("is_ready", 32'(s_if.bit_ready), 32'h1);
        shift_bits(16'h3C96, 8, 15, 16'h0000);
        s_if.bit_valid = 1'b0;
        check("is_wr_cen", 32'(cen), 32'h01);
        check("is_wr_cfg", 32'(config_out), 32'h3C96);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("is_end_busy", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
